clz_norm_pipe: RTL and testbench
================================

// Module: clz_norm_pipe
// PURPOSE
//  Pipelined, parametrised leading-zero/leading-one counter and normaliser.
//  Accepts one WIDTH-bit word per cycle over a valid/ready handshake.
//  Returns the leading count, an all-zero/all-one flag, and the word shifted
//  so that its first significant bit sits at index 0.
//  Feeds the float/fixed-point normalisation path behind the arithmetic units.
// PARAMETERS
//  WIDTH   8  data width; any value >= 2 (not restricted to powers of 2)
//  STAGES  2  pipeline depth = latency in cycles; legal range 1..3
//  CW      `CLOG2(WIDTH+1) (localparam) count width, so that WIDTH is representable
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        input word present
//  in_ready   out  1        block can accept this cycle
//  in_mode    in   1        0 = count leading zeros, 1 = count leading ones
//  in_data    in   [0:WIDTH-1]  index 0 is the first (most significant) bit
//  out_valid  out  1        result present
//  out_ready  in   1        downstream accepts result
//  out_count  out  CW       leading-bit count, 0..WIDTH
//  out_none   out  1        no significant bit found (count == WIDTH)
//  out_data   out  [0:WIDTH-1]  normalised word
//  out_mode   out  1        in_mode carried alongside the result
// BEHAVIOUR
//  - Transfer rules: input transfer when in_valid && in_ready; output transfer
//    when out_valid && out_ready.
//  - Significant bit:
//    - mode 0: the first 1 scanning from index 0.
//    - mode 1: the first 0 scanning from index 0.
//  - out_count = number of bits before the significant bit; WIDTH if none.
//  - out_none = (out_count == WIDTH).
//  - out_data = in_data shifted toward index 0 by out_count; vacated tail
//    positions fill with 0 in mode 0 and with 1 in mode 1.
//    If out_none, out_data = all 0 (mode 0) or all 1 (mode 1).
//  - Pipeline:
//    - STAGES registered stages, each with its own valid bit.
//    - Stage k advances when it is empty or stage k+1 advances; the last
//      stage advances on out_ready.
//    - in_ready = !valid[0] || advance[0]; it is combinational from
//      out_ready (no skid buffer).
//    - Bubbles collapse: a stalled head does not block an empty stage
//      from filling.
//  - Latency: accept at edge N -> out_valid high after edge N+STAGES-1
//    (combinationally visible in the cycle after the STAGES-th edge),
//    provided there is no backpressure.
//  - Throughput: 1 word/cycle while out_ready stays high.
//  - Stall: while out_valid && !out_ready, all out_* signals hold stable.
//    No word is lost or duplicated; order is preserved.
//  - Internal split of the tree across stages is free. Results must be
//    bit-identical for every STAGES value.
//  - Non-power-of-2 WIDTH: internally pad the tail with non-significant
//    bits up to the next power of 2. Padding never affects count, none or
//    data.
//  - Reset (async assert, released on clk): all stage valid bits cleared,
//    out_valid = 0, out_count = 0, out_none = 0, out_data = 0,
//    out_mode = 0, in_ready = 1 after release.
//    Reset during a transfer discards every in-flight word.
//  - Simultaneous accept and emit in the same cycle with a full pipeline
//    is legal and sustains full throughput.
// TESTING
//  1 W=8,S=2, mode0, data 8'b0001_0110 -> out 2 cycles later: count=3,
//    none=0, data=8'b1011_0000.
//  2 W=8, mode1, data 8'b1110_0101 -> count=3, data=8'b0010_1111;
//    data 8'hFF mode1 -> count=8, none=1, data=8'hFF.
//  3 W=8, mode0, data 8'h00 -> count=8, none=1, data=8'h00;
//    data 8'h80 -> count=0, data=8'h80.
//  4 W=12,S=3, mode0, data 12'h001 -> count=11, data=12'h800;
//    12'h000 -> count=12, none=1.
//  5 Back-to-back stream of 16 words, out_ready held low for 5 cycles
//    mid-stream -> in_ready drops once the pipe is full; outputs are stable
//    during the stall; all 16 results arrive in order with none lost.
//  6 rst asserted asynchronously with 2 words in flight -> out_valid falls
//    immediately; no stale result appears after release; first new word
//    returns with latency STAGES.

Source files
------------

// File: rtl/clz_norm_pipe.sv
// clz_norm_pipe -- pipelined leading-zero / leading-one counter and normaliser.
//
// Takes one WIDTH-bit word per cycle, finds the first significant bit
// (first 1 in mode 0, first 0 in mode 1, scanning from index 0), and returns
// the number of bits in front of it, a "none found" flag, and the word
// shifted so that the significant bit lands on index 0.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   input word present
//   in_ready   block can accept a word this cycle
//   in_mode    0 = count leading zeros, 1 = count leading ones
//   in_data    [0:WIDTH-1], index 0 is the most significant bit
//   out_valid  result present
//   out_ready  downstream accepts the result
//   out_count  leading-bit count, 0..WIDTH
//   out_none   no significant bit found (out_count == WIDTH)
//   out_data   [0:WIDTH-1] normalised word
//   out_mode   in_mode carried alongside the result
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high. A producer holding valid keeps its payload
// stable until that edge; ready may depend combinationally on the
// downstream ready (in_ready follows out_ready through the stage chain,
// there is no skid buffer).
//
// Datapath: the word is first XORed with the mode, which turns both modes
// into a leading-zero search. It is conceptually padded with zeros at the
// tail up to the next power of two P. A logarithmic normalising shifter
// then tests the top 2^b bits for b = log2(P)-1 down to 0: if they are all
// zero, it shifts left by 2^b and sets count bit b. Because the padding and
// the shifted-in bits are always zero, only the top WIDTH bits of the
// P-bit value are ever non-zero, so each stage stores just WIDTH bits.
// The shifter levels are spread evenly across the STAGES registers. Stages
// that get no level simply forward their data.

module clz_norm_pipe #(
  parameter  int WIDTH  = 8,
  parameter  int STAGES = 2,
  localparam int CW     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [0:WIDTH-1] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_none,
  output logic [0:WIDTH-1] out_data,
  output logic             out_mode
);

  // Shifter levels and the padded width they operate on.
  localparam int LP = $clog2(WIDTH);
  localparam int P  = 1 << LP;
  localparam int LAST = STAGES - 1;

  // Stage registers.
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] r_mode;
  logic [STAGES-1:0] r_none;
  logic [WIDTH-1:0]  r_x   [STAGES];
  logic [LP-1:0]     r_cnt [STAGES];

  // Per-stage inputs and combinational results.
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] sin_valid;
  logic [STAGES-1:0] sin_mode;
  logic [STAGES-1:0] sin_none;
  logic [WIDTH-1:0]  sin_x [STAGES];
  logic [LP-1:0]     sin_cnt [STAGES];
  logic [WIDTH-1:0]  c_x   [STAGES];
  logic [LP-1:0]     c_cnt [STAGES];

  // Mode-folded input, conventional bit order (bit WIDTH-1 = index 0).
  logic [WIDTH-1:0] prep_x;
  logic             prep_none;

  always_comb begin
    prep_x = '0;
    for (int j = 0; j < WIDTH; j++) begin
      prep_x[WIDTH-1-j] = in_data[j] ^ in_mode;
    end
    // The none flag is settled up front and carried as a register bit, so
    // that reset leaves out_none at 0 rather than deriving 1 from zero data.
    prep_none = ~|prep_x;
  end

  // Advance chain: a stage moves when it is empty or its successor moves.
  always_comb begin
    adv = '0;
    adv[LAST] = !v[LAST] || out_ready;
    for (int s = LAST - 1; s >= 0; s--) begin
      adv[s] = !v[s] || adv[s+1];
    end
  end

  assign in_ready = adv[0];

  // Stage inputs: stage 0 takes the prepared input word, later stages take
  // the previous stage's registers.
  always_comb begin
    sin_valid[0] = in_valid;
    sin_mode[0]  = in_mode;
    sin_none[0]  = prep_none;
    sin_x[0]     = prep_x;
    sin_cnt[0]   = '0;
    for (int s = 1; s < STAGES; s++) begin
      sin_valid[s] = v[s-1];
      sin_mode[s]  = r_mode[s-1];
      sin_none[s]  = r_none[s-1];
      sin_x[s]     = r_x[s-1];
      sin_cnt[s]   = r_cnt[s-1];
    end
  end

  // Normalising shifter levels. Level i (largest shift first) belongs to
  // stage (i*STAGES)/LP, which spreads the levels evenly across the stages.
  always_comb begin
    logic [P-1:0]  tx;
    logic [LP-1:0] tc;
    int            b;
    for (int s = 0; s < STAGES; s++) begin
      tx = P'(sin_x[s]) << (P - WIDTH);
      tc = sin_cnt[s];
      for (int i = 0; i < LP; i++) begin
        b = LP - 1 - i;
        if (((i * STAGES) / LP) == s) begin
          if ((tx >> (P - (1 << b))) == '0) begin
            tx    = tx << (1 << b);
            tc[b] = 1'b1;
          end
        end
      end
      c_x[s]   = tx[P-1 -: WIDTH];
      c_cnt[s] = tc;
    end
  end

  // Stage registers. Payload loads only with a valid word, so a held
  // output stage never changes while it waits for out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v      <= '0;
      r_mode <= '0;
      r_none <= '0;
      for (int s = 0; s < STAGES; s++) begin
        r_x[s]   <= '0;
        r_cnt[s] <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (adv[s]) begin
          v[s] <= sin_valid[s];
          if (sin_valid[s]) begin
            r_mode[s] <= sin_mode[s];
            r_none[s] <= sin_none[s];
            r_x[s]    <= c_x[s];
            r_cnt[s]  <= c_cnt[s];
          end
        end
      end
    end
  end

  // Output decode from the last stage. With no significant bit the shifter
  // count saturates at P-1, so it is replaced by WIDTH. The data is all
  // zeros, which unfolds to all-mode.
  always_comb begin
    out_valid = v[LAST];
    out_mode  = r_mode[LAST];
    out_none  = r_none[LAST];
    out_count = r_none[LAST] ? CW'(WIDTH) : CW'(r_cnt[LAST]);
    out_data  = '0;
    for (int j = 0; j < WIDTH; j++) begin
      out_data[j] = r_none[LAST] ? r_mode[LAST] : (r_x[LAST][WIDTH-1-j] ^ r_mode[LAST]);
    end
  end

endmodule

// File: tb/tb_clz_norm_pipe.sv
// Testbench for clz_norm_pipe: one instance at WIDTH=8/STAGES=2 and one at
// WIDTH=12/STAGES=3. It runs known vectors, a stalled stream, reset with
// words in flight, latency measurement, and a random stream against a
// scanning reference model.

module tb_clz_norm_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A: WIDTH 8, STAGES 2 ----------------
  logic        a_in_valid = 1'b0, a_in_ready, a_in_mode = 1'b0;
  logic [0:7]  a_in_data = '0;
  logic        a_out_valid, a_out_ready = 1'b1, a_out_none, a_out_mode;
  logic [3:0]  a_out_count;
  logic [0:7]  a_out_data;

  clz_norm_pipe #(.WIDTH(8), .STAGES(2)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_count(a_out_count),
    .out_none(a_out_none), .out_data(a_out_data), .out_mode(a_out_mode)
  );

  // ---------------- DUT B: WIDTH 12, STAGES 3 ----------------
  logic        b_in_valid = 1'b0, b_in_ready, b_in_mode = 1'b0;
  logic [0:11] b_in_data = '0;
  logic        b_out_valid, b_out_ready = 1'b1, b_out_none, b_out_mode;
  logic [3:0]  b_out_count;
  logic [0:11] b_out_data;

  clz_norm_pipe #(.WIDTH(12), .STAGES(3)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_count(b_out_count),
    .out_none(b_out_none), .out_data(b_out_data), .out_mode(b_out_mode)
  );

  // ---------------- scoreboard ----------------
  // Expected record: {mode, none, count[3:0], data[15:0]} (data right-aligned).
  logic [21:0] exp_a_q[$];
  logic [21:0] exp_b_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int a_rx = 0;
  int b_rx = 0;

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: scan for the first significant bit, then rebuild the word
  // position by position.
  function automatic logic [21:0] model(input logic [15:0] d, input int w, input bit m);
    int c;
    bit found;
    logic [15:0] o;
    c = w;
    found = 1'b0;
    for (int i = 0; i < w; i++) begin
      if (!found && d[w-1-i] != m) begin
        c = i;
        found = 1'b1;
      end
    end
    o = '0;
    for (int i = 0; i < w; i++) begin
      if (i + c < w) o[w-1-i] = d[w-1-i-c];
      else           o[w-1-i] = m;
    end
    return {m, (c == w), 4'(c), o};
  endfunction

  // Output monitors: whenever a result is shown it must equal the queue
  // head (this also covers stability during a stall); pop on transfer.
  always @(negedge clk) begin
    if (!rst && a_out_valid) begin
      if (exp_a_q.size() == 0) check("a_spurious_valid", 22'(a_out_valid), 22'(0));
      else begin
        check("a_result", {a_out_mode, a_out_none, a_out_count, 8'h00, a_out_data}, exp_a_q[0]);
        if (a_out_ready) begin
          void'(exp_a_q.pop_front());
          a_rx++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid) begin
      if (exp_b_q.size() == 0) check("b_spurious_valid", 22'(b_out_valid), 22'(0));
      else begin
        check("b_result", {b_out_mode, b_out_none, b_out_count, 4'h0, b_out_data}, exp_b_q[0]);
        if (b_out_ready) begin
          void'(exp_b_q.pop_front());
          b_rx++;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send_a(input logic [7:0] d, input bit m, input logic [21:0] e);
    int k = 0;
    a_in_valid = 1'b1; a_in_data = d; a_in_mode = m;
    @(negedge clk);
    while (!a_in_ready && k < 500) begin @(negedge clk); k++; end
    if (!a_in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL a_send_timeout: in_ready %b, expected 1", a_in_ready);
    end else exp_a_q.push_back(e);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [11:0] d, input bit m, input logic [21:0] e);
    int k = 0;
    b_in_valid = 1'b1; b_in_data = d; b_in_mode = m;
    @(negedge clk);
    while (!b_in_ready && k < 500) begin @(negedge clk); k++; end
    if (!b_in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL b_send_timeout: in_ready %b, expected 1", b_in_ready);
    end else exp_b_q.push_back(e);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && k < 300) begin
      @(posedge clk); k++;
    end
    #1;
    check("drain_left", 22'(exp_a_q.size() + exp_b_q.size()), 22'(0));
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_a_out"}, {a_out_valid, a_out_mode, a_out_none, a_out_count, a_out_data, 7'h0},
          22'(0));
    check({tag, "_b_out"}, {b_out_valid, b_out_mode, b_out_none, b_out_count, b_out_data, 3'h0},
          22'(0));
    check({tag, "_in_ready"}, 22'({a_in_ready, b_in_ready}), 22'(3));
  endtask

  // Measure edges from the accept edge to out_valid (accept edge counts as 1).
  task automatic latency_a(input int want);
    int lat;
    a_in_valid = 1'b1; a_in_data = 8'h29; a_in_mode = 1'b0;
    @(negedge clk);
    check("a_lat_in_ready", 22'(a_in_ready), 22'(1));
    exp_a_q.push_back(model(16'h0029, 8, 1'b0));
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    lat = 1;
    while (!a_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("a_latency", 22'(lat), 22'(want));
  endtask

  task automatic latency_b(input int want);
    int lat;
    b_in_valid = 1'b1; b_in_data = 12'hFC3; b_in_mode = 1'b1;
    @(negedge clk);
    check("b_lat_in_ready", 22'(b_in_ready), 22'(1));
    exp_b_q.push_back(model(16'h0FC3, 12, 1'b1));
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    lat = 1;
    while (!b_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("b_latency", 22'(lat), 22'(want));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          dut;   // 0 = A (W8), 1 = B (W12)
    logic [15:0] din;
    bit          mode;
    logic [3:0]  cnt;
    bit          none;
    logic [15:0] dout;
  } vec_t;

  vec_t tbl[17];
  bit   done = 1'b0;
  bit   saw_low = 1'b0;
  int   rx0;

  initial begin
    tbl[0]  = '{0, 16'h0016, 1'b0, 4'd3,  1'b0, 16'h00B0};
    tbl[1]  = '{0, 16'h00E5, 1'b1, 4'd3,  1'b0, 16'h002F};
    tbl[2]  = '{0, 16'h00FF, 1'b1, 4'd8,  1'b1, 16'h00FF};
    tbl[3]  = '{0, 16'h0000, 1'b0, 4'd8,  1'b1, 16'h0000};
    tbl[4]  = '{0, 16'h0080, 1'b0, 4'd0,  1'b0, 16'h0080};
    tbl[5]  = '{0, 16'h0001, 1'b0, 4'd7,  1'b0, 16'h0080};
    tbl[6]  = '{0, 16'h007F, 1'b1, 4'd0,  1'b0, 16'h007F};
    tbl[7]  = '{0, 16'h00FE, 1'b1, 4'd7,  1'b0, 16'h007F};
    tbl[8]  = '{0, 16'h003C, 1'b0, 4'd2,  1'b0, 16'h00F0};
    tbl[9]  = '{0, 16'h0000, 1'b1, 4'd0,  1'b0, 16'h0000};
    tbl[10] = '{1, 16'h0001, 1'b0, 4'd11, 1'b0, 16'h0800};
    tbl[11] = '{1, 16'h0000, 1'b0, 4'd12, 1'b1, 16'h0000};
    tbl[12] = '{1, 16'h0FFF, 1'b1, 4'd12, 1'b1, 16'h0FFF};
    tbl[13] = '{1, 16'h00F0, 1'b0, 4'd4,  1'b0, 16'h0F00};
    tbl[14] = '{1, 16'h07FF, 1'b1, 4'd0,  1'b0, 16'h07FF};
    tbl[15] = '{1, 16'h0800, 1'b0, 4'd0,  1'b0, 16'h0800};
    tbl[16] = '{1, 16'h0FFE, 1'b1, 4'd11, 1'b0, 16'h07FF};

    // Reset state, during and after reset.
    #12;
    reset_values("in_reset");
    #10 rst = 1'b0;
    #1;
    reset_values("after_reset");
    @(posedge clk); #1;

    // Known vectors, back to back.
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].dut == 0)
        send_a(tbl[i].din[7:0], tbl[i].mode, {tbl[i].mode, tbl[i].none, tbl[i].cnt, tbl[i].dout});
      else
        send_b(tbl[i].din[11:0], tbl[i].mode, {tbl[i].mode, tbl[i].none, tbl[i].cnt, tbl[i].dout});
    end
    drain();
    @(posedge clk); #1;

    // Latency with an empty pipe.
    latency_a(2);
    latency_b(3);
    drain();
    @(posedge clk); #1;

    // 16-word stream into A with a 5-cycle downstream stall mid-stream.
    rx0 = a_rx;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          logic [7:0] d;
          bit m;
          d = 8'($urandom);
          m = 1'($urandom_range(0, 1));
          send_a(d, m, model({8'h00, d}, 8, m));
        end
      end
      begin
        repeat (6) @(posedge clk);
        #1 a_out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          if (!a_in_ready) saw_low = 1'b1;
        end
        @(posedge clk);
        #1 a_out_ready = 1'b1;
      end
    join
    drain();
    check("stall_in_ready_drop", 22'(saw_low), 22'(1));
    check("stream_count", 22'(a_rx - rx0), 22'(16));
    @(posedge clk); #1;

    // Asynchronous reset with two words in flight in A.
    send_a(8'h0F, 1'b0, model(16'h000F, 8, 1'b0));
    send_a(8'hC1, 1'b1, model(16'h00C1, 8, 1'b1));
    check("pre_rst_valid", 22'(a_out_valid), 22'(1));
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 22'({a_out_valid, b_out_valid}), 22'(0));
    exp_a_q.delete();
    exp_b_q.delete();
    @(posedge clk); @(posedge clk); @(negedge clk);
    #2 rst = 1'b0;
    #1;
    reset_values("mid_reset");
    repeat (4) @(posedge clk);
    #1;
    latency_a(2);
    drain();
    @(posedge clk); #1;

    // Random traffic on both instances with random backpressure and gaps.
    fork
      begin
        fork
          begin
            for (int i = 0; i < 150; i++) begin
              logic [7:0] d;
              bit m;
              d = 8'($urandom);
              if ($urandom_range(0, 3) == 0) d = d >> $urandom_range(0, 8);
              m = 1'($urandom_range(0, 1));
              if (m && $urandom_range(0, 3) == 0) d = ~(d >> $urandom_range(0, 8));
              send_a(d, m, model({8'h00, d}, 8, m));
              repeat ($urandom_range(0, 1) * $urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
          end
          begin
            for (int i = 0; i < 150; i++) begin
              logic [11:0] d;
              bit m;
              d = 12'($urandom);
              if ($urandom_range(0, 3) == 0) d = d >> $urandom_range(0, 12);
              m = 1'($urandom_range(0, 1));
              if (m && $urandom_range(0, 3) == 0) d = ~(d >> $urandom_range(0, 12));
              send_b(d, m, model({4'h0, d}, 12, m));
              repeat ($urandom_range(0, 1) * $urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
          end
        join
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          a_out_ready = ($urandom_range(0, 3) != 0);
          b_out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule
